reg_debug_port: RTL and testbench

Debug initiator for the 32x32 register file: on command it walks the register file through its read port and streams every register out over a valid/ready channel (dump), or accepts a stream of words and writes them into registers 1..31 through the write port (load). Sits between the debug/host link and the register file, and holds the CPU core stalled while it owns the register file ports.

---
 rtl/reg_debug_port_if.sv | 36 +++
 rtl/reg_debug_port.sv | 144 ++++++++++++++
 tb/tb_reg_debug_port.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/reg_debug_port_if.sv
// Signal bundle between the debug port, the host link and the register file ports.
// The slave modport is the debug port; the master modport is the host/register-file side.
interface reg_debug_port_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 5
);
  logic              DBG_start;
  logic              DBG_mode;
  logic              DBG_busy;
  logic              DBG_cpu_hold;
  logic              DBG_done;
  logic [IDX_W-1:0]  REG_address;
  logic [DATA_W-1:0] REG_data_in;
  logic [IDX_W-1:0]  REG_address_wr;
  logic              REG_write;
  logic [DATA_W-1:0] REG_data_wr;
  logic [DATA_W-1:0] DBG_out_data;
  logic [IDX_W-1:0]  DBG_out_addr;
  logic              DBG_out_valid;
  logic              DBG_out_ready;
  logic [DATA_W-1:0] DBG_in_data;
  logic              DBG_in_valid;
  logic              DBG_in_ready;

  modport slave (
    input  DBG_start, DBG_mode, REG_data_in, DBG_out_ready, DBG_in_data, DBG_in_valid,
    output DBG_busy, DBG_cpu_hold, DBG_done, REG_address, REG_address_wr, REG_write,
           REG_data_wr, DBG_out_data, DBG_out_addr, DBG_out_valid, DBG_in_ready
  );

  modport master (
    output DBG_start, DBG_mode, REG_data_in, DBG_out_ready, DBG_in_data, DBG_in_valid,
    input  DBG_busy, DBG_cpu_hold, DBG_done, REG_address, REG_address_wr, REG_write,
           REG_data_wr, DBG_out_data, DBG_out_addr, DBG_out_valid, DBG_in_ready
  );
endinterface

// File: rtl/reg_debug_port.sv
// Debug initiator for the register file: dumps every register over a valid/ready
// stream, or loads a word stream into registers 1..N-1, stalling the core meanwhile.
module reg_debug_port #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DATA_W   = 32
) (
  input logic            DBG_clk,
  input logic            DBG_rst_n,
  reg_debug_port_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DUMP_RD   = 3'd1,
    ST_DUMP_HOLD = 3'd2,
    ST_LOAD      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  logic [DATA_W-1:0] out_data, out_data_nx;
  logic [IDX_W-1:0]  out_addr, out_addr_nx;
  logic              out_valid, out_valid_nx;

  logic              busy_c;
  logic              done_c;
  logic [IDX_W-1:0]  rd_addr_c;
  logic [IDX_W-1:0]  wr_addr_c;
  logic              wr_en_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              in_ready_c;

  // State, index and dump output registers; reset aborts any transfer in flight.
  always_ff @(posedge DBG_clk or negedge DBG_rst_n) begin
    if (!DBG_rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      out_data  <= out_data_nx;
      out_addr  <= out_addr_nx;
      out_valid <= out_valid_nx;
    end
  end

  // Next-state and register-port decode.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    out_data_nx  = out_data;
    out_addr_nx  = out_addr;
    out_valid_nx = out_valid;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    rd_addr_c    = '0;
    wr_addr_c    = '0;
    wr_en_c      = 1'b0;
    wr_data_c    = '0;
    in_ready_c   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (bus.DBG_start) begin
          if (bus.DBG_mode) begin
            idx_nx   = IDX_W'(1);
            state_nx = ST_LOAD;
          end else begin
            idx_nx   = '0;
            state_nx = ST_DUMP_RD;
          end
        end
      end

      ST_DUMP_RD: begin
        busy_c       = 1'b1;
        rd_addr_c    = idx;
        out_data_nx  = bus.REG_data_in;
        out_addr_nx  = idx;
        out_valid_nx = 1'b1;
        state_nx     = ST_DUMP_HOLD;
      end

      ST_DUMP_HOLD: begin
        busy_c = 1'b1;
        // Word stays on the channel until the host takes it.
        if (out_valid && bus.DBG_out_ready) begin
          out_valid_nx = 1'b0;
          if (idx == LAST_IDX) begin
            state_nx = ST_DONE;
          end else begin
            idx_nx   = idx + IDX_W'(1);
            state_nx = ST_DUMP_RD;
          end
        end
      end

      ST_LOAD: begin
        busy_c     = 1'b1;
        in_ready_c = 1'b1;
        wr_addr_c  = idx;
        wr_data_c  = bus.DBG_in_data;
        // Register 0 is hardwired; never drive a write to it.
        wr_en_c    = bus.DBG_in_valid && (idx != '0);
        if (bus.DBG_in_valid) begin
          if (idx == LAST_IDX) begin
            state_nx = ST_DONE;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end
      end

      ST_DONE: begin
        done_c   = 1'b1;
        state_nx = ST_IDLE;
      end

      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign bus.DBG_busy       = busy_c;
  assign bus.DBG_cpu_hold   = busy_c;
  assign bus.DBG_done       = done_c;
  assign bus.REG_address    = rd_addr_c;
  assign bus.REG_address_wr = wr_addr_c;
  assign bus.REG_write      = wr_en_c;
  assign bus.REG_data_wr    = wr_data_c;
  assign bus.DBG_in_ready   = in_ready_c;
  assign bus.DBG_out_data   = out_data;
  assign bus.DBG_out_addr   = out_addr;
  assign bus.DBG_out_valid  = out_valid;

endmodule

// File: tb/tb_reg_debug_port.sv
// Self-checking bench for reg_debug_port: register-file model, dump scoreboard,
// gapped/stalled handshakes, ignored starts and asynchronous reset mid-load.
module tb_reg_debug_port;

  localparam int unsigned NREGS  = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned BUDGET = 400;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  reg_debug_port_if #(.DATA_W(DW), .IDX_W(5)) bus ();

  reg_debug_port #(.NUM_REGS(NREGS), .DATA_W(DW)) dut (
    .DBG_clk   (clk),
    .DBG_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rf    [NREGS];
  logic [31:0] img   [NREGS];
  logic [31:0] model [NREGS];
  logic        pre_load = 1'b0;

  // Register file: combinational read, write on the rising edge.
  always @(posedge clk) begin
    if (pre_load) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= img[i];
    end else if (bus.REG_write) begin
      rf[bus.REG_address_wr] <= bus.REG_data_wr;
    end
  end
  assign bus.REG_data_in = rf[bus.REG_address];

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  bit   stalled = 1'b0;
  logic [31:0] hold_d;
  logic [4:0]  hold_a;
  bit   wr0_seen = 1'b0;
  bit   done_busy_seen = 1'b0;
  bit   hold_ne_busy = 1'b0;
  int   last_busy;
  int   last_done_at;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dump-channel monitor: scoreboard pop on handshake, stability during stall.
  always @(negedge clk) begin
    if (bus.REG_write && bus.REG_address_wr == 5'd0) wr0_seen = 1'b1;
    if (bus.DBG_done && bus.DBG_busy) done_busy_seen = 1'b1;
    if (bus.DBG_cpu_hold !== bus.DBG_busy) hold_ne_busy = 1'b1;
    if (stalled && bus.DBG_out_valid) begin
      check("stall_data", 64'(bus.DBG_out_data), 64'(hold_d));
      check("stall_addr", 64'(bus.DBG_out_addr), 64'(hold_a));
    end
    if (bus.DBG_out_valid && bus.DBG_out_ready) begin
      if (q.size() == 0) begin
        check("dump_extra_word", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check("dump_addr", 64'(bus.DBG_out_addr), 64'(e.a));
        check("dump_data", 64'(bus.DBG_out_data), 64'(e.d));
      end
    end
    stalled = bus.DBG_out_valid && !bus.DBG_out_ready;
    hold_d  = bus.DBG_out_data;
    hold_a  = bus.DBG_out_addr;
  end

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < int'(NREGS); i++) img[i] = (i == 0) ? 32'h0 : base + 32'(i);
    @(posedge clk); #1 pre_load = 1'b1;
    @(posedge clk); #1 pre_load = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) model[i] = img[i];
  endtask

  function automatic logic ready_pat(input int n);
    logic [3:0] pat;
    pat = 4'b1001;
    return pat[n % 4];
  endfunction

  // Start a dump; optionally stall with a 1-0-0-1 ready pattern and poke start/mode.
  task automatic run_dump(input bit pattern, input bit poke);
    int n;
    int busy_cnt;
    bit done_seen;
    for (int i = 0; i < int'(NREGS); i++) q.push_back('{a: 5'(i), d: model[i]});
    @(posedge clk); #1 bus.DBG_start = 1'b1; bus.DBG_mode = 1'b0;
    @(posedge clk); #1 bus.DBG_start = 1'b0;
    n = 1; busy_cnt = 0; done_seen = 1'b0; last_done_at = 0;
    bus.DBG_out_ready = pattern ? ready_pat(n) : 1'b1;
    while (n < int'(BUDGET)) begin
      @(negedge clk);
      if (bus.DBG_busy) busy_cnt++;
      if (bus.DBG_done) begin
        done_seen = 1'b1; last_done_at = n;
        break;
      end
      @(posedge clk); #1;
      n++;
      bus.DBG_out_ready = pattern ? ready_pat(n) : 1'b1;
      if (poke && n >= 10) begin
        bus.DBG_start = 1'b1;
        bus.DBG_mode  = n[0];
      end
    end
    if (!done_seen) check("dump_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 bus.DBG_start = 1'b0; bus.DBG_mode = 1'b0; bus.DBG_out_ready = 1'b0;
    last_busy = busy_cnt;
    check("dump_all_words_seen", 64'(q.size()), 64'(0));
    q.delete();
  endtask

  // Start a load of words base+k into reg k+1; optional gaps and reset after abort_after words.
  task automatic run_load(input logic [31:0] base, input bit gap, input int abort_after,
                          output int last_hs);
    int n;
    int k;
    int busy_cnt;
    bit done_seen;
    @(posedge clk); #1 bus.DBG_start = 1'b1; bus.DBG_mode = 1'b1;
    @(posedge clk); #1 bus.DBG_start = 1'b0; bus.DBG_mode = 1'b0;
    n = 1; k = 0; busy_cnt = 0; done_seen = 1'b0; last_hs = 0; last_done_at = 0;
    bus.DBG_in_valid = gap ? (n % 3 != 0) : 1'b1;
    bus.DBG_in_data  = base + 32'(k);
    while (n < int'(BUDGET)) begin
      @(negedge clk);
      if (bus.DBG_busy) busy_cnt++;
      if (bus.DBG_done) begin
        done_seen = 1'b1; last_done_at = n;
        break;
      end
      if (bus.DBG_in_ready && bus.DBG_in_valid) begin
        check("load_wr_en", 64'(bus.REG_write), 64'(1));
        check("load_wr_addr", 64'(bus.REG_address_wr), 64'(k + 1));
        model[k + 1] = base + 32'(k);
        k++;
        last_hs = n;
      end
      @(posedge clk); #1;
      n++;
      bus.DBG_in_valid = gap ? (n % 3 != 0) : 1'b1;
      bus.DBG_in_data  = base + 32'(k);
      if (abort_after != 0 && k == abort_after) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 64'(bus.DBG_busy), 64'(0));
        check("rst_hold", 64'(bus.DBG_cpu_hold), 64'(0));
        check("rst_wr_en", 64'(bus.REG_write), 64'(0));
        check("rst_in_ready", 64'(bus.DBG_in_ready), 64'(0));
        check("rst_done", 64'(bus.DBG_done), 64'(0));
        check("rst_out_valid", 64'(bus.DBG_out_valid), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        bus.DBG_in_valid = 1'b0;
        rst_n = 1'b1;
        last_busy = busy_cnt;
        return;
      end
    end
    if (!done_seen) check("load_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 bus.DBG_in_valid = 1'b0;
    last_busy = busy_cnt;
  endtask

  task automatic check_rf(input string tag);
    for (int i = 0; i < int'(NREGS); i++) check(tag, 64'(rf[i]), 64'(model[i]));
  endtask

  initial begin
    int hs;
    bus.DBG_start = 1'b0; bus.DBG_mode = 1'b0; bus.DBG_out_ready = 1'b0;
    bus.DBG_in_data = '0; bus.DBG_in_valid = 1'b0;
    for (int i = 0; i < int'(NREGS); i++) begin
      img[i] = '0; model[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(bus.DBG_busy), 64'(0));
    check("reset_done", 64'(bus.DBG_done), 64'(0));
    check("reset_out_valid", 64'(bus.DBG_out_valid), 64'(0));
    check("reset_in_ready", 64'(bus.DBG_in_ready), 64'(0));
    check("reset_wr_en", 64'(bus.REG_write), 64'(0));
    check("reset_rd_addr", 64'(bus.REG_address), 64'(0));
    rst_n = 1'b1;

    preload(32'hA500_0000);
    run_dump(1'b0, 1'b0);
    check("dump_busy_cycles", 64'(last_busy), 64'(64));
    check("dump_done_cycle", 64'(last_done_at), 64'(65));

    run_dump(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("no_restart_after_done", 64'(bus.DBG_busy), 64'(0));

    run_load(32'h0000_1000, 1'b1, 0, hs);
    check("gap_load_done_cycle", 64'(last_done_at), 64'(hs + 1));
    check("gap_load_busy", 64'(last_busy), 64'(hs));
    check("gap_load_hs_cycle", 64'(hs), 64'(46));
    @(posedge clk); #1 check_rf("gap_load_rf");

    run_dump(1'b0, 1'b0);

    run_load(32'h0000_2000, 1'b0, 0, hs);
    check("full_load_done_cycle", 64'(last_done_at), 64'(32));
    check("full_load_busy", 64'(last_busy), 64'(31));
    @(posedge clk); #1 check_rf("full_load_rf");

    preload(32'hA500_0000);
    run_load(32'h0000_3000, 1'b0, 10, hs);
    check_rf("abort_load_rf");
    run_dump(1'b0, 1'b0);
    check("post_reset_dump_done", 64'(last_done_at), 64'(65));

    check("no_write_to_reg0", 64'(wr0_seen), 64'(0));
    check("done_busy_exclusive", 64'(done_busy_seen), 64'(0));
    check("hold_equals_busy", 64'(hold_ne_busy), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
